// File: rtl/imap_biu.sv
// imap_biu: input feature map read BIU.
// Fetches MAP_WORDS consecutive words from the arbiter starting at the sampled
// base address and streams them in order to the map buffer. Outstanding reads
// are limited by credits so the response FIFO can never overflow.
// Optional build macro IMAP_BIU_PERF_CNT_EN adds the imap_stall_cnt port.
module imap_biu #(
  parameter int MAP_WORDS  = 200704,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imap_base_addr,
  input  logic        conv_start,
  output logic        imap_biu2arb_req,
  output logic [31:0] imap_biu2arb_addr,
  output logic        imap_biu2arb_vld,
  input  logic        imap_biu2arb_rdy,
  input  logic [31:0] arb2imap_biu_data,
  input  logic        arb2imap_biu_vld,
  output logic        arb2imap_biu_rdy,
  output logic [31:0] imap_biu2buf_data,
  output logic        imap_biu2buf_vld,
  input  logic        imap_biu2buf_rdy,
  output logic        imap_done,
  output logic        imap_busy
`ifdef IMAP_BIU_PERF_CNT_EN
  ,
  output logic [31:0] imap_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAP_WORDS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAP_WORDS - 1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CRD_W-1:0] credits;
  logic [31:0]      addr_q;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CRD_W-1:0] fifo_cnt;
  logic [CRD_W-1:0] fifo_cnt_next;
  logic             rsp_rdy_q;

  logic start_acc;
  logic req_hs;
  logic rsp_hs;
  logic dn_hs;
  logic last_req;
  logic last_dn;
  logic fifo_empty;

  assign start_acc  = conv_start && (state == IDLE);
  assign req_hs     = imap_biu2arb_vld && imap_biu2arb_rdy;
  assign rsp_hs     = arb2imap_biu_vld && rsp_rdy_q;
  assign dn_hs      = imap_biu2buf_vld && imap_biu2buf_rdy;
  assign last_req   = req_hs && (iss_cnt == LAST_IDX);
  assign last_dn    = dn_hs && (out_cnt == LAST_IDX);
  assign fifo_empty = (fifo_cnt == '0);

  // Request valid only while issuing and a FIFO slot is reserved for the reply.
  assign imap_biu2arb_vld  = (state == ISSUE) && (credits != '0);
  assign imap_biu2arb_addr = addr_q;
  assign arb2imap_biu_rdy  = rsp_rdy_q;
  assign imap_biu2buf_vld  = !fifo_empty;
  assign imap_biu2buf_data = fifo_empty ? 32'h0 : mem[rd_ptr];

  // Control FSM with registered req/busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      imap_biu2arb_req <= 1'b0;
      imap_busy        <= 1'b0;
      imap_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (conv_start) begin
            state            <= ISSUE;
            imap_biu2arb_req <= 1'b1;
            imap_busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (last_req) begin
            state            <= DRAIN;
            imap_biu2arb_req <= 1'b0;
          end
        end
        DRAIN: begin
          if (last_dn) begin
            state     <= DONE;
            imap_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          imap_done <= 1'b0;
          imap_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue/delivery counters, credits, and the request address (tracks base + iss_cnt).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_cnt <= '0;
      out_cnt <= '0;
      credits <= CRD_FULL;
      addr_q  <= 32'h0;
    end else if (start_acc) begin
      iss_cnt <= '0;
      out_cnt <= '0;
      credits <= CRD_FULL;
      addr_q  <= imap_base_addr;
    end else begin
      if (req_hs) begin
        iss_cnt <= iss_cnt + CNT_W'(1);
        addr_q  <= addr_q + 32'd1;
      end
      if (dn_hs) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (req_hs && !dn_hs) begin
        credits <= credits - CRD_W'(1);
      end else if (!req_hs && dn_hs) begin
        credits <= credits + CRD_W'(1);
      end
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (rsp_hs && !dn_hs) begin
      fifo_cnt_next = fifo_cnt + CRD_W'(1);
    end else if (!rsp_hs && dn_hs) begin
      fifo_cnt_next = fifo_cnt - CRD_W'(1);
    end
  end

  // FIFO pointers and occupancy; response ready is registered from next occupancy so it reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rsp_rdy_q <= 1'b0;
    end else begin
      if (rsp_hs) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (dn_hs) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt  <= fifo_cnt_next;
      rsp_rdy_q <= (fifo_cnt_next != CRD_FULL);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (rsp_hs) begin
      mem[wr_ptr] <= arb2imap_biu_data;
    end
  end

`ifdef IMAP_BIU_PERF_CNT_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt      = (imap_biu2arb_vld && !imap_biu2arb_rdy) ||
                          ((state == ISSUE) && (credits == '0));
  assign imap_stall_cnt = stall_q;

  // Saturating count of arbiter back-pressure and credit-starved issue cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'h0;
    end else if (start_acc) begin
      stall_q <= 32'h0;
    end else if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imap_biu.sv
// Randomized scoreboard bench for imap_biu (MAP_WORDS=16, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_imap_biu;
  localparam int MW = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imap_base_addr = 32'h0;
  logic        conv_start = 1'b0;
  logic        arb_req;
  logic [31:0] arb_addr;
  logic        arb_vld;
  logic        arb_rdy = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_vld = 1'b0;
  logic        rsp_rdy;
  logic [31:0] buf_data;
  logic        buf_vld;
  logic        buf_rdy = 1'b0;
  logic        done;
  logic        busy;
`ifdef IMAP_BIU_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  imap_biu #(.MAP_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk               (clk),
    .rst               (rst),
    .imap_base_addr    (imap_base_addr),
    .conv_start        (conv_start),
    .imap_biu2arb_req  (arb_req),
    .imap_biu2arb_addr (arb_addr),
    .imap_biu2arb_vld  (arb_vld),
    .imap_biu2arb_rdy  (arb_rdy),
    .arb2imap_biu_data (rsp_data),
    .arb2imap_biu_vld  (rsp_vld),
    .arb2imap_biu_rdy  (rsp_rdy),
    .imap_biu2buf_data (buf_data),
    .imap_biu2buf_vld  (buf_vld),
    .imap_biu2buf_rdy  (buf_rdy),
    .imap_done         (done),
    .imap_busy         (busy)
`ifdef IMAP_BIU_PERF_CNT_EN
    ,
    .imap_stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory behind the arbiter: each address holds a distinct word.
  function automatic logic [31:0] ref_mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Scoreboard queues, filled when a map fetch is started.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // Traffic modes.
  bit arb_rand  = 0;
  bit resp_rand = 0;
  bit buf_rand  = 0;
  bit buf_hold  = 0;

  // Monitor state.
  int          issued = 0;
  int          delivered = 0;
  int          done_cnt = 0;
  int          stall_model = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = 32'h0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;
  resp_t resp_q[$];

  // Arbiter and downstream driver: inputs change at negedge, handshakes resolved before the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_q.delete();
        arb_rdy  = 1'b0;
        rsp_vld  = 1'b0;
        rsp_data = 32'h0;
        buf_rdy  = 1'b0;
        continue;
      end
      arb_rdy = arb_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      buf_rdy = buf_hold ? 1'b0 : (buf_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        rsp_vld  = 1'b1;
        rsp_data = resp_q[0].data;
      end else begin
        rsp_vld  = 1'b0;
        rsp_data = 32'h0;
      end
      #1;
      if (rst) continue;
      if (arb_vld && arb_rdy) begin
        resp_t r;
        r.data = ref_mem(arb_addr);
        r.due  = cyc + 1 + (resp_rand ? int'($urandom_range(0, 2)) : 0);
        resp_q.push_back(r);
      end
      if (rsp_vld && rsp_rdy) void'(resp_q.pop_front());
    end
  end

  // Monitor: compares every request and every delivered word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall  = 0;
        issued      = 0;
        delivered   = 0;
        stall_model = 0;
        continue;
      end
      if (conv_start && !busy) begin
        issued      = 0;
        delivered   = 0;
        stall_model = 0;
      end
      if (prev_stall) begin
        chk("stall_hold_vld", 32'(arb_vld), 32'd1);
        chk("stall_hold_addr", arb_addr, prev_addr);
      end
      prev_stall = arb_vld && !arb_rdy;
      prev_addr  = arb_addr;
      if ((arb_vld && !arb_rdy) || (arb_req && !arb_vld)) stall_model++;
      if (arb_vld && arb_rdy) begin
        chk("credit_limit", 32'(issued - delivered < FD), 32'd1);
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_addr: got unexpected request %h expected none", arb_addr);
        end else begin
          chk("req_addr", arb_addr, exp_addr_q.pop_front());
        end
        issued++;
      end
      if (rsp_vld) chk("rsp_rdy_when_vld", 32'(rsp_rdy), 32'd1);
      if (buf_vld && buf_rdy) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL buf_data: got unexpected word %h expected none", buf_data);
        end else begin
          chk("buf_data", buf_data, exp_data_q.pop_front());
        end
        $display("word %0d data %h", delivered, buf_data);
        delivered++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_map(input logic [31:0] base);
    @(negedge clk);
    imap_base_addr = base;
    conv_start     = 1'b1;
    for (int i = 0; i < MW; i++) begin
      exp_addr_q.push_back(base + 32'(i));
      exp_data_q.push_back(ref_mem(base + 32'(i)));
    end
    @(negedge clk);
    conv_start     = 1'b0;
    imap_base_addr = $urandom;
    #3;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_delivered(input int n);
    int k = 0;
    while (delivered < n && k < 2000) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("delivered_timeout", 32'(delivered >= n), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("done_timeout", 32'(done_cnt != d0), 32'd1);
    @(negedge clk);
    #3;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("issued_total", 32'(issued), 32'(MW));
    chk("delivered_total", 32'(delivered), 32'(MW));
    chk("scoreboard_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);
    $display("map %s complete: %0d words", name, delivered);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    chk("reset_ctrl", {26'h0, arb_req, arb_vld, buf_vld, done, busy, rsp_rdy}, 32'h0);
    chk("reset_addr", arb_addr, 32'h0);
    chk("reset_data", buf_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain fetch, everything ready, 1-cycle responses.
    start_map(32'h0000_1000);
    wait_done("basic");

    // Downstream blocked: only FIFO_DEPTH requests may go out.
    buf_hold = 1;
    start_map(32'h0000_3000);
    repeat (20) @(negedge clk);
    #3;
    chk("blocked_issued", 32'(issued), 32'(FD));
    chk("blocked_arb_vld", 32'(arb_vld), 32'd0);
    chk("blocked_buf_vld", 32'(buf_vld), 32'd1);
    buf_hold = 0;
    wait_done("blocked");

    // Random arbiter back-pressure, response delay and downstream readiness.
    arb_rand  = 1;
    resp_rand = 1;
    buf_rand  = 1;
    for (int r = 0; r < 3; r++) begin
      start_map($urandom);
      wait_done("random");
    end
    arb_rand  = 0;
    resp_rand = 0;
    buf_rand  = 0;

    // Address wrap across 2^32.
    start_map(32'hFFFF_FFFE);
    wait_done("wrap");

    // Abort by reset after 7 words, then restart cleanly.
    start_map(32'h0000_5000);
    wait_delivered(7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {26'h0, arb_req, arb_vld, buf_vld, done, busy, rsp_rdy}, 32'h0);
    chk("abort_addr", arb_addr, 32'h0);
    chk("abort_data", buf_data, 32'h0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_map(32'h0000_2000);
    wait_done("restart");

    // Second conv_start mid-transfer must be ignored.
    arb_rand = 1;
    start_map(32'h0000_7000);
    wait_delivered(5);
    @(negedge clk);
    conv_start     = 1'b1;
    imap_base_addr = 32'hDEAD_0000;
    @(negedge clk);
    conv_start     = 1'b0;
    wait_done("restart_ignored");
`ifdef IMAP_BIU_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(stall_model));
`endif
    arb_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
